// File: rtl/decoder_pkg.sv
// Shared types and widths for the pulse-stretching 3-to-8 decoder.
package decoder_pkg;
    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
        return OUT_W'(1) << code;
    endfunction
endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter shared by hold and gap timing; parks at zero, never wraps.
module hold_counter
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/decoder_pulse.sv
// 3-to-8 decoder that stretches each accepted code into a timed one-hot pulse,
// with a one-deep pending slot and overflow flag.
//
//   state | meaning
//   IDLE  | no pulse, pending slot empty, ready for a code
//   DRIVE | one O line high, counting HOLD_CYCLES
//   GAP   | all O lines low, counting GAP_CYCLES
module decoder_pulse
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic val,
    output logic rdy,
    output logic O1,
    output logic O2,
    output logic O3,
    output logic O4,
    output logic O5,
    output logic O6,
    output logic O7,
    output logic O8,
    output logic busy,
    output logic ovf
);
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("decoder_pulse: HOLD_CYCLES must be 1..15");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("decoder_pulse: GAP_CYCLES must be 0..15");
    end

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
    localparam bit               GAP_NONE = (GAP_CYCLES == 0);

    state_t              state, state_nxt;
    logic [OUT_W-1:0]    out_q, out_nxt;
    logic                busy_q, ovf_q;
    logic                pend_vld;
    logic [CODE_W-1:0]   pend_code;
    logic [CODE_W-1:0]   code_in, drive_code;
    logic                accept, tc, last;
    logic                cnt_load, pend_set, pend_clr, go_drive;
    logic [CNT_W-1:0]    cnt_ld_val;

    assign code_in = {D1, D2, D3};
    assign rdy     = ~pend_vld;
    assign accept  = val & rdy;
    // End of the busy period: last gap cycle, or last hold cycle when there is no gap.
    assign last    = tc & ((state == GAP) | ((state == DRIVE) & GAP_NONE));

    hold_counter u_hold_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .tc       (tc)
    );

    always_comb begin
        state_nxt  = state;
        out_nxt    = out_q;
        cnt_load   = 1'b0;
        cnt_ld_val = HOLD_LD;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        go_drive   = 1'b0;
        drive_code = code_in;
        case (state)
            IDLE: go_drive = accept;
            DRIVE, GAP: begin
                if (last) begin
                    if (pend_vld) begin
                        go_drive   = 1'b1;
                        drive_code = pend_code;
                        pend_clr   = 1'b1;
                    end else if (accept) begin
                        go_drive = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        out_nxt   = '0;
                    end
                end else begin
                    if (state == DRIVE && tc) begin
                        state_nxt  = GAP;
                        out_nxt    = '0;
                        cnt_load   = 1'b1;
                        cnt_ld_val = GAP_LD;
                    end
                    pend_set = accept;
                end
            end
            default: begin
                state_nxt = IDLE;
                out_nxt   = '0;
            end
        endcase
        // A new line replaces the old one in a single edge, so two lines are never high together.
        if (go_drive) begin
            state_nxt  = DRIVE;
            out_nxt    = code_to_onehot(drive_code);
            cnt_load   = 1'b1;
            cnt_ld_val = HOLD_LD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_q     <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            pend_vld  <= 1'b0;
            pend_code <= '0;
        end else begin
            state  <= state_nxt;
            out_q  <= out_nxt;
            busy_q <= (state_nxt != IDLE);
            ovf_q  <= val & ~rdy;
            if (pend_clr) begin
                pend_vld <= 1'b0;
            end else if (pend_set) begin
                pend_vld  <= 1'b1;
                pend_code <= code_in;
            end
        end
    end

    assign {O8, O7, O6, O5, O4, O3, O2, O1} = out_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_decoder_pulse.sv
// Directed bench for decoder_pulse: vector table plus hand-written corner sequences.
module tb_decoder_pulse;
    logic clk = 1'b0;
    logic rst_n, val;
    logic [2:0] code;
    logic mon_en = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    logic rdy_a, busy_a, ovf_a;
    logic [7:0] o_a;
    logic rdy_b, busy_b, ovf_b;
    logic [7:0] o_b;

    always #5 clk = ~clk;

    decoder_pulse dut (
        .clk(clk), .rst_n(rst_n), .D1(code[2]), .D2(code[1]), .D3(code[0]), .val(val),
        .rdy(rdy_a), .O1(o_a[0]), .O2(o_a[1]), .O3(o_a[2]), .O4(o_a[3]),
        .O5(o_a[4]), .O6(o_a[5]), .O7(o_a[6]), .O8(o_a[7]), .busy(busy_a), .ovf(ovf_a)
    );

    decoder_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .D1(code[2]), .D2(code[1]), .D3(code[0]), .val(val),
        .rdy(rdy_b), .O1(o_b[0]), .O2(o_b[1]), .O3(o_b[2]), .O4(o_b[3]),
        .O5(o_b[4]), .O6(o_b[5]), .O7(o_b[6]), .O8(o_b[7]), .busy(busy_b), .ovf(ovf_b)
    );

    typedef struct {
        logic       rst_n;
        logic       val;
        logic [2:0] code;
        logic       chk;
        logic [7:0] o;
        logic       busy;
        logic       rdy;
        logic       ovf;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d actual %h required %h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic v, input logic [2:0] c, input logic k,
                       input logic [7:0] o, input logic b, input logic rd, input logic ov);
        tbl.push_back('{r, v, c, k, o, b, rd, ov});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; val = 1'b0; code = 3'd0;
        tick();
        rst_n = 1'b1;
    endtask

    // Never more than one line high on either instance.
    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot_a", 0, 32'($countones(o_a) <= 1), 32'd1);
            check("onehot_b", 0, 32'($countones(o_b) <= 1), 32'd1);
        end
    end

    initial begin
        int hits, wrong;
        logic [7:0] exp_line;

        // reset with inputs toggling, then single code 5
        add(0, 1, 3'd5, 0, 8'h00, 0, 1, 0);
        add(0, 1, 3'd3, 1, 8'h00, 0, 1, 0);
        add(1, 1, 3'd5, 1, 8'h00, 0, 1, 0);
        add(1, 0, 3'd0, 1, 8'h20, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h20, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h20, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h20, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h00, 1, 1, 0);
        // back-to-back 0 then 7
        add(1, 1, 3'd0, 1, 8'h00, 0, 1, 0);
        add(1, 1, 3'd7, 1, 8'h01, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h01, 1, 0, 0);
        add(1, 0, 3'd0, 1, 8'h01, 1, 0, 0);
        add(1, 0, 3'd0, 1, 8'h01, 1, 0, 0);
        add(1, 0, 3'd0, 1, 8'h00, 1, 0, 0);
        add(1, 0, 3'd0, 1, 8'h80, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h80, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h80, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h80, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h00, 1, 1, 0);
        // overflow: 2, 4, 6 on consecutive cycles
        add(1, 1, 3'd2, 1, 8'h00, 0, 1, 0);
        add(1, 1, 3'd4, 1, 8'h04, 1, 1, 0);
        add(1, 1, 3'd6, 1, 8'h04, 1, 0, 0);
        add(1, 0, 3'd0, 1, 8'h04, 1, 0, 1);
        add(1, 0, 3'd0, 1, 8'h04, 1, 0, 0);
        add(1, 0, 3'd0, 1, 8'h00, 1, 0, 0);
        add(1, 0, 3'd0, 1, 8'h10, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h10, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h10, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h10, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h00, 1, 1, 0);
        add(1, 0, 3'd0, 1, 8'h00, 0, 1, 0);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n;
            val   = tbl[i].val;
            code  = tbl[i].code;
            if (tbl[i].chk)
                check("table", i, {21'd0, o_a, busy_a, rdy_a, ovf_a},
                      {21'd0, tbl[i].o, tbl[i].busy, tbl[i].rdy, tbl[i].ovf});
            tick();
            mon_en = 1'b1;
        end

        // every code, fully spaced
        do_reset();
        for (int k = 0; k < 8; k++) begin
            val = 1'b1; code = 3'(k);
            exp_line = 8'h01 << k;
            check("allcodes_idle", k, {23'd0, o_a, busy_a}, 32'd0);
            tick();
            val = 1'b0;
            hits = 0; wrong = 0;
            for (int c = 1; c < 8; c++) begin
                if (o_a == exp_line) hits++;
                else if (o_a != 8'h00) wrong++;
                tick();
            end
            check("allcodes_hold", k, 32'(hits), 32'd4);
            check("allcodes_other", k, 32'(wrong), 32'd0);
        end

        // GAP_CYCLES=0 instance: code 2 presented on last hold cycle of code 1
        do_reset();
        val = 1'b1; code = 3'd1;
        check("bypass_idle", 0, {24'd0, o_b}, 32'd0);
        tick();
        val = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin val = 1'b1; code = 3'd2; end
            check("bypass_o2", c, {23'd0, o_b, busy_b}, {23'd0, 8'h02, 1'b1});
            tick();
            val = 1'b0;
        end
        for (int c = 5; c <= 8; c++) begin
            check("bypass_o3", c, {23'd0, o_b, busy_b}, {23'd0, 8'h04, 1'b1});
            tick();
        end
        check("bypass_end", 9, {22'd0, o_b, busy_b, rdy_b}, {22'd0, 8'h00, 1'b0, 1'b1});

        // reset in the middle of a hold, with a code presented during reset
        do_reset();
        val = 1'b1; code = 3'd3;
        tick();
        val = 1'b0;
        check("rstmid_c1", 1, {24'd0, o_a}, {24'd0, 8'h08});
        tick();
        check("rstmid_c2", 2, {24'd0, o_a}, {24'd0, 8'h08});
        rst_n = 1'b0; val = 1'b1; code = 3'd5;
        tick();
        rst_n = 1'b1; val = 1'b0;
        check("rstmid_after", 3, {21'd0, o_a, busy_a, rdy_a, ovf_a}, {21'd0, 8'h00, 1'b0, 1'b1, 1'b0});
        for (int c = 4; c < 12; c++) begin
            tick();
            check("rstmid_quiet", c, {23'd0, o_a, busy_a}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/decoder_pulse.md
DECODER_PULSE -- requirements
Module: decoder_pulse

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles a decoded output line stays high; legal range 1..15.
REQ-002 Parameter GAP_CYCLES, default 1: cycles all outputs stay low after a hold; legal range 0..15.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low.
REQ-005 Ports D1, D2, D3  input  1 each: 3-bit code {D1,D2,D3}, D1 = MSB.
REQ-006 Port val  input  1: code valid, sampled each rising edge.
REQ-007 Port rdy  output  1: the block can accept a code this cycle.
REQ-008 Ports O1..O8  output  1 each: one-hot decoded lines; code k drives O(k+1).
REQ-009 Port busy  output  1: high when the state is not IDLE.
REQ-010 Port ovf  output  1: one-cycle pulse when a code is dropped.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, DRIVE and GAP.
REQ-012 A code is accepted on a rising edge where val=1 and rdy=1.
REQ-013 rdy SHALL be the inverse of the 1-deep pending-slot valid flag; in IDLE the slot is always empty.
REQ-014 IDLE plus accept: the next state is DRIVE, and the selected O line goes high on the following cycle (latency 1, registered output).
REQ-015 DRIVE: exactly one O line is high, for exactly HOLD_CYCLES consecutive cycles; then the FSM moves to GAP, or skips GAP if GAP_CYCLES=0.
REQ-016 GAP: all O lines are low for exactly GAP_CYCLES cycles.
REQ-017 On the last hold/gap cycle, if the pending slot is valid, the FSM enters DRIVE with the pending code and clears the slot; otherwise it enters IDLE.
REQ-018 Accept during DRIVE or GAP: the code is stored in the pending slot.
REQ-019 Simultaneous last cycle, empty slot and accept: the new code bypasses the slot and goes straight to DRIVE, with no idle cycle between.
REQ-020 val=1 while rdy=0: the code is discarded, ovf=1 on the next cycle, and the held and pending codes are unchanged.
REQ-021 The internal hold/gap counter SHALL be 4 bits wide; it loads on a state entry, decrements, and never wraps.
REQ-022 O1..O8 SHALL be registered and never show more than one line high at once, including at state transitions.
REQ-023 busy SHALL be registered and high in DRIVE and GAP.
REQ-024 The counter SHALL be 4 bits wide, so parameter values above 15 are illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-025 rst_n=0 at an edge: the state becomes IDLE, the counter is cleared, the pending slot is emptied, O1..O8=0, busy=0, ovf=0 and rdy=1 on the next cycle.
REQ-026 Reset asserted mid-DRIVE or mid-GAP SHALL abort the operation with no residual pulse after release.
REQ-027 Inputs SHALL be ignored while rst_n=0.

Structure
REQ-028 Shared package decoder_pkg: the state encoding (IDLE, DRIVE, GAP), CODE_W=3, OUT_W=8 and CNT_W=4.
REQ-029 One sub-module, hold_counter: a loadable down-counter with a terminal-count output, used for both hold and gap timing.

Verification
REQ-030 Reset then a single code: code 3'b101 with val for 1 cycle -> O6=1 from cycle +1 through +4, low at +5 (GAP), busy low at +6.
REQ-031 All codes: each code 0..7 in turn, fully spaced -> only O(k+1) pulses, for exactly 4 cycles each; one-hot is checked every cycle.
REQ-032 Back-to-back codes: 3'b000 and then 3'b111 one cycle later -> O1 for 4 cycles, 1 gap cycle, O8 for 4 cycles; rdy low while the slot is full.
REQ-033 Overflow: three codes on consecutive cycles (2, 4, 6) -> O3 then O5 pulses; the code 6 is dropped and ovf pulses once.
REQ-034 GAP_CYCLES=0 with bypass: code 1, and code 2 presented on the last hold cycle -> O2 then O3 contiguous, with no all-zero cycle.
REQ-035 Reset mid-DRIVE: rst_n low for 1 cycle at hold cycle 2 -> all outputs 0 the next cycle, rdy=1, and no further pulse.
